// File: rtl/mem_host_arb_pkg.sv
// Shared types and helpers for the two-host RAM arbiter.
package mem_host_arb_pkg;

  typedef enum logic {HostA = 1'b0, HostB = 1'b1} host_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  localparam int unsigned DEPTH_DEF = 128;

  // Word index addr[31:2] must fall below the RAM depth.
  function automatic logic in_range(input logic [31:0] addr, input int unsigned depth);
    return ({2'b00, addr[31:2]} < 32'(depth));
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the host granted most recently loses the next tie.
module rr_arb2
  import mem_host_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output host_e      win_o,
  output logic       any_o
);

  host_e r_last;
  host_e w_win;

  always_comb begin
    w_win = HostA;
    if (req_i == 2'b11)       w_win = (r_last == HostA) ? HostB : HostA;
    else if (req_i[1])        w_win = HostB;
  end

  assign any_o = |req_i;
  assign win_o = w_win;
  assign gnt_o = any_o ? ((w_win == HostB) ? 2'b10 : 2'b01) : 2'b00;

  // Reset to B so the first tie after reset goes to A.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    r_last <= HostB;
    else if (any_o) r_last <= w_win;
  end

endmodule

// File: rtl/mem_host_arb.sv
// Arbitrates two Ibex-style hosts onto one single-port RAM and routes each
// response back to its issuer; out-of-range accesses complete locally with err.
module mem_host_arb
  import mem_host_arb_pkg::*;
#(
  parameter int unsigned Depth = DEPTH_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        a_req_i,
  output logic        a_gnt_o,
  input  logic        a_we_i,
  input  logic [3:0]  a_be_i,
  input  logic [31:0] a_addr_i,
  input  logic [31:0] a_wdata_i,
  output logic        a_rvalid_o,
  output logic [31:0] a_rdata_o,
  output logic        a_err_o,

  input  logic        b_req_i,
  output logic        b_gnt_o,
  input  logic        b_we_i,
  input  logic [3:0]  b_be_i,
  input  logic [31:0] b_addr_i,
  input  logic [31:0] b_wdata_i,
  output logic        b_rvalid_o,
  output logic [31:0] b_rdata_o,
  output logic        b_err_o,

  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_be_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic        ram_rvalid_i,
  input  logic [31:0] ram_rdata_i
);

  logic [1:0] w_gnt;
  host_e      w_win;
  logic       w_any;
  cmd_t       w_cmd_a, w_cmd_b, w_cmd, w_fwd;
  logic       w_inrange;
  logic       w_fwd_req;

  logic       r_pend;
  host_e      r_owner;
  logic       r_err;

  rr_arb2 u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  ({b_req_i, a_req_i}),
    .gnt_o  (w_gnt),
    .win_o  (w_win),
    .any_o  (w_any)
  );

  assign a_gnt_o = w_gnt[0];
  assign b_gnt_o = w_gnt[1];

  assign w_cmd_a = '{we: a_we_i, be: a_be_i, addr: a_addr_i, wdata: a_wdata_i};
  assign w_cmd_b = '{we: b_we_i, be: b_be_i, addr: b_addr_i, wdata: b_wdata_i};
  assign w_cmd   = (w_win == HostB) ? w_cmd_b : w_cmd_a;

  assign w_inrange = in_range(w_cmd.addr, Depth);
  assign w_fwd_req = w_any && w_inrange;
  assign w_fwd     = w_fwd_req ? w_cmd : '0;

  assign ram_req_o   = w_fwd_req;
  assign ram_we_o    = w_fwd.we;
  assign ram_be_o    = w_fwd.be;
  assign ram_addr_o  = w_fwd.addr;
  assign ram_wdata_o = w_fwd.wdata;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend  <= 1'b0;
      r_owner <= HostA;
      r_err   <= 1'b0;
    end else begin
      r_pend  <= w_any;
      r_owner <= w_any ? w_win : HostA;
      r_err   <= w_any && !w_inrange;
    end
  end

  // Responses come purely from tracking state; ram_rvalid_i never gates them,
  // so a stray RAM rvalid cannot reach a host.
  logic w_a_own, w_b_own;
  assign w_a_own = r_pend && (r_owner == HostA);
  assign w_b_own = r_pend && (r_owner == HostB);

  assign a_rvalid_o = w_a_own;
  assign a_err_o    = w_a_own && r_err;
  assign a_rdata_o  = (w_a_own && !r_err) ? ram_rdata_i : 32'h0;
  assign b_rvalid_o = w_b_own;
  assign b_err_o    = w_b_own && r_err;
  assign b_rdata_o  = (w_b_own && !r_err) ? ram_rdata_i : 32'h0;

  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(ram_rvalid_i && !(r_pend && !r_err)))
        else $warning("mem_host_arb: ram_rvalid_i with no forwarded request pending");
    end
  end

endmodule
